clock_time_multi: RTL
=====================

Name: clock_time_multi

Overview:
Parametrised millisecond time base with N independent one-shot countdown channels. A free-running prescaler divides the system clock into ticks; a TIME_W-bit tick counter answers timestamp queries over the start_port/done_port/return_port handshake. Per-channel deadline timers raise sticky expiry flags and a combined interrupt. Software uses it for timeouts without polling.

Parameters:
CLOCK_RATIO, 200000, system clocks per tick (200 MHz gives 1 ms tick); legal range is 2 or more.
TIME_W, 32, width of the tick counter, return_port, and arm_delay.
N_CH, 4, number of countdown channels (1..16); CH_W = max(1, clog2(N_CH)).

Ports:
clock  in  1  system clock; all logic on posedge.
reset  in  1  synchronous, active-low reset.
start_port  in  1  timestamp query request.
done_port  out  1  one-cycle query completion pulse.
return_port  out  TIME_W  timestamp captured by the query.
arm_valid  in  1  load channel arm_ch with arm_delay.
arm_ch  in  CH_W  channel index for arm.
arm_delay  in  TIME_W  countdown length in ticks.
cancel_valid  in  1  deactivate channel cancel_ch without expiry.
cancel_ch  in  CH_W  channel index for cancel.
clear_mask  in  N_CH  write-1-to-clear for expired bits; applied every cycle.
expired  out  N_CH  sticky per-channel expiry flags.
active  out  N_CH  per-channel running flags.
irq  out  1  OR of expired.
freeze  in  1  present only with CLOCK_TIME_FREEZE_EN.

Behaviour:
- Reset (reset==0 at posedge): prescaler, tick counter, all channel counters, active, expired, done_port, and return_port go to 0. irq is 0 one cycle later.
- Prescaler:
  - Counts 0..CLOCK_RATIO-1 and wraps to 0.
  - tick is asserted in the cycle where prescaler==CLOCK_RATIO-1, giving exactly one tick per CLOCK_RATIO clocks.
  - The first tick occurs at the CLOCK_RATIO-th posedge after reset release.
- Tick counter: increments by 1 on each tick and wraps modulo 2^TIME_W with no saturation and no flag.
- Query:
  - When start_port is 1 at posedge N, done_port is 1 during cycle N+1.
  - return_port equals the counter value before any increment at edge N.
  - done_port is low in all other cycles.
  - return_port holds its value until the next query.
  - start_port held high produces done_port every cycle, each with a fresh value.
- Channel arm:
  - arm_valid loads remain[arm_ch]=arm_delay, sets active=1, and clears expired[arm_ch] at the same edge.
  - Re-arming an active channel restarts it.
  - arm_ch >= N_CH is ignored.
- Countdown:
  - On each tick, every active channel with remain>1 decrements.
  - A channel with remain==1 goes to remain=0 and active=0, and sets expired=1.
  - A channel armed in a tick cycle is not decremented that tick.
  - arm_delay==0 causes expiry at the next posedge regardless of tick, giving expired=1 two edges after arm.
  - Expiry latency from arm with delay D>0 is D ticks, with a partial first tick (0..CLOCK_RATIO-1 clocks early).
- Cancel: cancel_valid clears active[cancel_ch] and leaves expired unchanged. Arm and cancel on the same channel in the same cycle: arm wins.
- Clear: expired[i] is cleared when clear_mask[i]==1. A set (expiry or arm-clear) in the same cycle takes priority over the clear, so an expiry coinciding with a clear leaves expired=1.
- irq: registered OR of expired, one cycle behind expired.
- Reset mid-countdown discards all channels. No expiry is reported.

Optional Feature:
CLOCK_TIME_FREEZE_EN:
- Defined:
  - The freeze port exists.
  - While freeze==1, the prescaler, tick counter, and all countdowns hold, and no tick is generated.
  - Queries, arm, cancel, and clear still operate.
  - Counting resumes from the held prescaler value on release.
- Undefined: no freeze port; the time base always runs.

Test Plan:
(all with CLOCK_RATIO=4, TIME_W=8, N_CH=4)
1. Release reset, wait 41 clocks, pulse start_port -> done_port=1 for exactly 1 cycle, return_port=10.
2. Run 1024 clocks from reset -> tick counter wraps 255->0 at tick 256; query at tick 257 returns 1.
3. Arm ch2 with delay 3 immediately after a tick -> expired=4'b0100 after 3 ticks (12 clocks, ±1); irq=1 on the next cycle. clear_mask=4'b0100 -> expired=0, irq=0.
4. Arm ch0 delay 5, cancel ch0 after 2 ticks -> active[0]=0, expired[0] never sets. Arm ch1 delay 0 -> expired[1]=1 two edges later.
5. Same cycle: arm ch3 delay 2 and cancel ch3 -> active[3]=1, expires after 2 ticks. Expiry cycle coincides with clear_mask[3]=1 -> expired[3] stays 1.
6. With CLOCK_TIME_FREEZE_EN: arm ch0 delay 2, assert freeze for 20 clocks -> no expiry and counter unchanged during freeze; expiry occurs 2 ticks of unfrozen time after arm.

Source files
------------

// File: rtl/clock_time_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | clock_time_multi: prescaled tick counter with timestamp query and N_CH     |
// | one-shot countdown channels. Optional CLOCK_TIME_FREEZE_EN adds freeze.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module clock_time_multi #(
  parameter int CLOCK_RATIO = 200000,
  parameter int TIME_W      = 32,
  parameter int N_CH        = 4,
  localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_port,
  output logic              done_port,
  output logic [TIME_W-1:0] return_port,
  input  logic              arm_valid,
  input  logic [CH_W-1:0]   arm_ch,
  input  logic [TIME_W-1:0] arm_delay,
  input  logic              cancel_valid,
  input  logic [CH_W-1:0]   cancel_ch,
  input  logic [N_CH-1:0]   clear_mask,
  output logic [N_CH-1:0]   expired,
  output logic [N_CH-1:0]   active,
  output logic              irq
`ifdef CLOCK_TIME_FREEZE_EN
  ,
  input  logic              freeze
`endif
);

  localparam int              PS_W    = $clog2(CLOCK_RATIO);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLOCK_RATIO - 1);

  logic [PS_W-1:0]   prescaler;
  logic [TIME_W-1:0] tick_count;
  logic              run;
  logic              tick;
  logic [TIME_W-1:0] remain [N_CH];
  logic [N_CH-1:0]   arm_hit;
  logic [N_CH-1:0]   cancel_hit;
  logic [N_CH-1:0]   fire;

`ifdef CLOCK_TIME_FREEZE_EN
  assign run = ~freeze;
`else
  assign run = 1'b1;
`endif

  assign tick = run && (prescaler == PS_LAST);

  always_ff @(posedge clock) begin
    if (!reset) begin
      prescaler  <= '0;
      tick_count <= '0;
    end else if (run) begin
      prescaler <= tick ? '0 : prescaler + PS_W'(1);
      if (tick) begin
        tick_count <= tick_count + TIME_W'(1);
      end
    end
  end

  // Query samples the counter before this edge's increment.
  always_ff @(posedge clock) begin
    if (!reset) begin
      done_port   <= 1'b0;
      return_port <= '0;
    end else begin
      done_port <= start_port;
      if (start_port) begin
        return_port <= tick_count;
      end
    end
  end

  // Arm beats cancel beats countdown; a zero remain expires without a tick.
  always_comb begin
    arm_hit    = '0;
    cancel_hit = '0;
    fire       = '0;
    for (int i = 0; i < N_CH; i++) begin
      arm_hit[i]    = arm_valid && (arm_ch == CH_W'(i));
      cancel_hit[i] = cancel_valid && (cancel_ch == CH_W'(i));
      fire[i]       = !arm_hit[i] && !cancel_hit[i] && active[i] &&
                      ((remain[i] == '0) || (tick && (remain[i] == TIME_W'(1))));
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < N_CH; i++) begin
        remain[i] <= '0;
      end
      active  <= '0;
      expired <= '0;
      irq     <= 1'b0;
    end else begin
      irq <= |expired;
      for (int i = 0; i < N_CH; i++) begin
        if (arm_hit[i]) begin
          remain[i] <= arm_delay;
          active[i] <= 1'b1;
        end else if (cancel_hit[i]) begin
          active[i] <= 1'b0;
        end else if (fire[i]) begin
          remain[i] <= '0;
          active[i] <= 1'b0;
        end else if (active[i] && tick) begin
          remain[i] <= remain[i] - TIME_W'(1);
        end
        // Expiry wins over a coincident clear.
        expired[i] <= fire[i] | (expired[i] & ~clear_mask[i] & ~arm_hit[i]);
      end
    end
  end

endmodule
`default_nettype wire
